gmux_quad_ctrl: RTL and testbench

GMUX_QUAD_CTRL -- requirements
Module: gmux_quad_ctrl

---
 rtl/gmux_quad_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_gmux_quad_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmux_quad_ctrl.sv
// ---------------------------------------------------------------------------
// gmux_quad_ctrl
//
// Purpose:
//    Sequences the four quadrant clock enables of a global clock mux (GMUX).
//    Each quadrant (TL, TR, BL, BR) runs its own small power FSM:
//       OFF -> RAMP_ON -> ON -> RAMP_OFF -> OFF, and OFF -> SLEEP after a
//       long idle stretch. Ramps always run to completion so the GMUX never
//       sees an enable glitch. The global source select is only allowed to
//       change while no quadrant clock is running or ramping.
//
// Parameters:
//    SETTLE_CYC  cycles a quadrant spends in each ramp state
//    IDLE_CYC    consecutive idle OFF cycles before a quadrant sleeps
//    CNT_W       width of each per-quadrant counter
//
// Ports (bit 0=TL, 1=TR, 2=BL, 3=BR on every 4-bit port):
//    clk       single clock, all state changes on the rising edge
//    rst       synchronous, active-high reset
//    req       per-quadrant clock request
//    wake      returns every sleeping quadrant to OFF
//    ssel_req  requested global clock source select
//    ssel      applied source select to the GMUX SSEL pin
//    sen       per-quadrant static enable
//    den       per-quadrant dynamic enable
//    dynen     per-quadrant dynamic-mode select
//    vlp       per-quadrant very-low-power request
//    ack       per-quadrant clock-running indication
//    busy      a ramp or a source-select change is in progress
// ---------------------------------------------------------------------------
module gmux_quad_ctrl #(
   parameter int SETTLE_CYC = 4,
   parameter int IDLE_CYC   = 64,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       wake,
   input  logic       ssel_req,
   output logic       ssel,
   output logic [3:0] sen,
   output logic [3:0] den,
   output logic [3:0] dynen,
   output logic [3:0] vlp,
   output logic [3:0] ack,
   output logic       busy
);

   typedef enum logic [2:0] {
      OFF      = 3'd0,
      RAMP_ON  = 3'd1,
      ON       = 3'd2,
      RAMP_OFF = 3'd3,
      SLEEP    = 3'd4
   } quadState_e;

   // Terminal counter values: a transition fires on the edge where the
   // counter would reach the full duration, so compare against duration-1.
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   quadState_e       stateQ    [4];
   quadState_e       stateNext [4];
   logic [CNT_W-1:0] cntQ      [4];
   logic [CNT_W-1:0] cntNext   [4];

   logic       allIdle;
   logic       sselUpdate;
   logic       sselNext;
   logic       anyRampNext;
   logic [3:0] senNext;
   logic [3:0] denNext;
   logic [3:0] dynenNext;
   logic [3:0] vlpNext;
   logic [3:0] ackNext;

   // The source select may only move while every quadrant clock is stopped
   // (OFF or SLEEP). sselUpdate marks an edge where it actually changes;
   // that edge also holds back any OFF->RAMP_ON so a ramp never starts on
   // the same edge the GMUX switches source.
   always_comb begin
      allIdle = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (stateQ[i] != OFF && stateQ[i] != SLEEP) begin
            allIdle = 1'b0;
         end
      end
      sselUpdate = allIdle && (ssel_req != ssel);
      sselNext   = sselUpdate ? ssel_req : ssel;
   end

   // Per-quadrant next-state and counter logic, followed by the output
   // decode of the next state. Decoding the next state lets the outputs be
   // registered yet still line up cycle-for-cycle with the state register.
   // The counter doubles as ramp timer and idle timer; it is cleared on
   // every state entry that needs a fresh count.
   always_comb begin
      anyRampNext = 1'b0;
      senNext     = '0;
      denNext     = '0;
      dynenNext   = '0;
      vlpNext     = '0;
      ackNext     = '0;
      for (int i = 0; i < 4; i++) begin
         stateNext[i] = stateQ[i];
         cntNext[i]   = cntQ[i];
         case (stateQ[i])
            OFF: begin
               if (req[i]) begin
                  if (!sselUpdate) begin
                     stateNext[i] = RAMP_ON;
                     cntNext[i]   = '0;
                  end
               end else begin
                  if (cntQ[i] != CNT_MAX) begin
                     cntNext[i] = cntQ[i] + 1'b1;
                  end
                  if (cntQ[i] >= IDLE_LAST) begin
                     stateNext[i] = SLEEP;
                  end
               end
            end
            RAMP_ON: begin
               if (cntQ[i] >= SETTLE_LAST) begin
                  stateNext[i] = ON;
                  cntNext[i]   = '0;
               end else begin
                  cntNext[i] = cntQ[i] + 1'b1;
               end
            end
            ON: begin
               if (!req[i]) begin
                  stateNext[i] = RAMP_OFF;
                  cntNext[i]   = '0;
               end
            end
            RAMP_OFF: begin
               if (cntQ[i] >= SETTLE_LAST) begin
                  stateNext[i] = OFF;
                  cntNext[i]   = '0;
               end else begin
                  cntNext[i] = cntQ[i] + 1'b1;
               end
            end
            SLEEP: begin
               if (req[i] || wake) begin
                  stateNext[i] = OFF;
                  cntNext[i]   = '0;
               end
            end
            default: begin
               stateNext[i] = OFF;
               cntNext[i]   = '0;
            end
         endcase

         senNext[i]   = (stateNext[i] == ON);
         ackNext[i]   = (stateNext[i] == ON);
         denNext[i]   = (stateNext[i] == RAMP_ON) || (stateNext[i] == RAMP_OFF);
         dynenNext[i] = (stateNext[i] == OFF) || (stateNext[i] == RAMP_ON) ||
                        (stateNext[i] == RAMP_OFF);
         vlpNext[i]   = (stateNext[i] == SLEEP);
         anyRampNext  = anyRampNext || denNext[i];
      end
   end

   // State, counters and all outputs are registered together. busy compares
   // the new select against this edge's ssel_req, which is exactly the
   // "previous-cycle request" once the new cycle begins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            stateQ[i] <= OFF;
            cntQ[i]   <= '0;
         end
         ssel  <= 1'b0;
         sen   <= 4'b0000;
         den   <= 4'b0000;
         dynen <= 4'b1111;
         vlp   <= 4'b0000;
         ack   <= 4'b0000;
         busy  <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            stateQ[i] <= stateNext[i];
            cntQ[i]   <= cntNext[i];
         end
         ssel  <= sselNext;
         sen   <= senNext;
         den   <= denNext;
         dynen <= dynenNext;
         vlp   <= vlpNext;
         ack   <= ackNext;
         busy  <= anyRampNext || (sselNext != ssel_req);
      end
   end

endmodule

// File: tb/tb_gmux_quad_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gmux_quad_ctrl
//
// Directed testbench for gmux_quad_ctrl with default parameters. Cycle 0 is
// the cycle right after the reset edge; outputs are sampled 1 time unit
// after each rising edge and inputs are driven at the same point, so a value
// driven in cycle N is sampled on the edge that starts cycle N+1.
// All outputs are packed into one word {ssel, sen, den, dynen, vlp, ack,
// busy} and compared against a word built from per-quadrant state codes.
// ---------------------------------------------------------------------------
module tb_gmux_quad_ctrl;

   // Per-quadrant output codes {sen, den, dynen, vlp, ack}
   localparam logic [4:0] E_OFF  = 5'b00100;
   localparam logic [4:0] E_RON  = 5'b01100;
   localparam logic [4:0] E_ON   = 5'b10001;
   localparam logic [4:0] E_ROFF = 5'b01100;
   localparam logic [4:0] E_SLP  = 5'b00010;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       wake;
   logic       ssel_req;
   logic       ssel;
   logic [3:0] sen;
   logic [3:0] den;
   logic [3:0] dynen;
   logic [3:0] vlp;
   logic [3:0] ack;
   logic       busy;

   logic [21:0] obsWord;
   int          errors;
   int          checks;

   gmux_quad_ctrl dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .wake     (wake),
      .ssel_req (ssel_req),
      .ssel     (ssel),
      .sen      (sen),
      .den      (den),
      .dynen    (dynen),
      .vlp      (vlp),
      .ack      (ack),
      .busy     (busy)
   );

   assign obsWord = {ssel, sen, den, dynen, vlp, ack, busy};

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Assemble the expected output word from per-quadrant codes
   function automatic logic [21:0] expWord(input logic s, input logic [4:0] q3,
                                           input logic [4:0] q2, input logic [4:0] q1,
                                           input logic [4:0] q0, input logic b);
      return {s,
              q3[4], q2[4], q1[4], q0[4],
              q3[3], q2[3], q1[3], q0[3],
              q3[2], q2[2], q1[2], q0[2],
              q3[1], q2[1], q1[1], q0[1],
              q3[0], q2[0], q1[0], q0[0],
              b};
   endfunction

   // Advance to 1 time unit after the next rising edge
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Drive all functional inputs at once
   task automatic applyStimulus(input logic [3:0] r, input logic w, input logic s);
      req      = r;
      wake     = w;
      ssel_req = s;
   endtask

   // Reset with idle inputs; returns in cycle 0 with rst released
   task automatic doReset();
      rst = 1'b1;
      applyStimulus(4'b0000, 1'b0, 1'b0);
      nextCycle();
      rst = 1'b0;
   endtask

   // Reset wins over active requests, wake and a select request
   task automatic test_reset();
      logic [21:0] e;
      rst = 1'b1;
      applyStimulus(4'b1111, 1'b1, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         nextCycle();
         e = expWord(1'b0, E_OFF, E_OFF, E_OFF, E_OFF, 1'b0);
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL reset c=%0d got=%h want=%h", c, obsWord, e);
         end
      end
      doReset();
   endtask

   // TL request: RAMP_ON cycles 1-4, ON from cycle 5, busy only while ramping
   task automatic test_ramp_on();
      logic [21:0] e;
      logic [4:0]  q0;
      doReset();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         nextCycle();
         q0 = (c <= 4) ? E_RON : E_ON;
         e  = expWord(1'b0, E_OFF, E_OFF, E_OFF, q0, (c <= 4));
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL ramp_on c=%0d got=%h want=%h", c, obsWord, e);
         end
      end
   endtask

   // Dropping TL request mid-ramp does not abort: ON only at cycle 5
   task automatic test_no_abort();
      logic [21:0] e;
      logic [4:0]  q0;
      doReset();
      applyStimulus(4'b0001, 1'b0, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         nextCycle();
         if (c <= 4)       q0 = E_RON;
         else if (c == 5)  q0 = E_ON;
         else if (c <= 9)  q0 = E_ROFF;
         else              q0 = E_OFF;
         e = expWord(1'b0, E_OFF, E_OFF, E_OFF, q0, (c <= 4) || (c >= 6 && c <= 9));
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL no_abort c=%0d got=%h want=%h", c, obsWord, e);
         end
         if (c == 2) applyStimulus(4'b0000, 1'b0, 1'b0);
      end
   endtask

   // Idle to SLEEP at 64, wake at 70, sleep again at 135, TR request exits
   // SLEEP at 136 and ramps at 137
   task automatic test_sleep_wake();
      logic [21:0] e;
      logic [4:0]  qa;
      logic [4:0]  q1;
      doReset();
      for (int c = 1; c <= 137; c++) begin
         nextCycle();
         if (c < 64)       qa = E_OFF;
         else if (c <= 70) qa = E_SLP;
         else if (c < 135) qa = E_OFF;
         else              qa = E_SLP;
         q1 = qa;
         if (c == 136) q1 = E_OFF;
         if (c == 137) q1 = E_RON;
         e = expWord(1'b0, qa, qa, q1, qa, (c == 137));
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL sleep_wake c=%0d got=%h want=%h", c, obsWord, e);
         end
         if (c == 70)  applyStimulus(4'b0000, 1'b1, 1'b0);
         if (c == 71)  applyStimulus(4'b0000, 1'b0, 1'b0);
         if (c == 135) applyStimulus(4'b0010, 1'b0, 1'b0);
      end
   endtask

   // Select request while TR runs: ssel holds until TR is back in OFF
   task automatic test_ssel_hold();
      logic [21:0] e;
      logic [4:0]  q1;
      doReset();
      applyStimulus(4'b0010, 1'b0, 1'b0);
      for (int c = 1; c <= 13; c++) begin
         nextCycle();
         if (c <= 4)       q1 = E_RON;
         else if (c <= 6)  q1 = E_ON;
         else if (c <= 10) q1 = E_ROFF;
         else              q1 = E_OFF;
         e = expWord((c >= 12), E_OFF, E_OFF, q1, E_OFF, (c <= 4) || (c >= 6 && c <= 11));
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL ssel_hold c=%0d got=%h want=%h", c, obsWord, e);
         end
         if (c == 5) applyStimulus(4'b0010, 1'b0, 1'b1);
         if (c == 6) applyStimulus(4'b0000, 1'b0, 1'b1);
      end
   endtask

   // Continues from ssel=1: select change and BR request in the same cycle;
   // select moves first, BR ramps one cycle later
   task automatic test_ssel_first();
      logic [21:0] e;
      logic [4:0]  q3;
      applyStimulus(4'b1000, 1'b0, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         nextCycle();
         q3 = (c == 1) ? E_OFF : E_RON;
         e  = expWord(1'b0, q3, E_OFF, E_OFF, E_OFF, (c >= 2));
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL ssel_first c=%0d got=%h want=%h", c, obsWord, e);
         end
      end
   endtask

   // All quadrants together, then TL/BL drop; TL re-requests mid RAMP_OFF and
   // only ramps up again after the ramp-down completes
   task automatic test_back_to_back();
      logic [21:0] e;
      logic [4:0]  q0;
      logic [4:0]  q2;
      logic [4:0]  qh;
      doReset();
      applyStimulus(4'b1111, 1'b0, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         nextCycle();
         qh = (c <= 4) ? E_RON : E_ON;
         if (c <= 4)       q2 = E_RON;
         else if (c == 5)  q2 = E_ON;
         else if (c <= 9)  q2 = E_ROFF;
         else              q2 = E_OFF;
         q0 = (c == 11) ? E_RON : q2;
         e = expWord(1'b0, qh, q2, qh, q0, (c <= 4) || (c >= 6 && c <= 9) || (c == 11));
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL back_to_back c=%0d got=%h want=%h", c, obsWord, e);
         end
         if (c == 5) applyStimulus(4'b1010, 1'b0, 1'b0);
         if (c == 6) applyStimulus(4'b1011, 1'b0, 1'b0);
      end
   endtask

   // Reset during BL RAMP_OFF with request re-raised: reset state first,
   // RAMP_ON one cycle after reset drops
   task automatic test_reset_mid_ramp();
      logic [21:0] e;
      logic [4:0]  q2;
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         nextCycle();
         if (c <= 4)       q2 = E_RON;
         else if (c == 5)  q2 = E_ON;
         else if (c <= 7)  q2 = E_ROFF;
         else if (c == 8)  q2 = E_OFF;
         else              q2 = E_RON;
         e = expWord(1'b0, E_OFF, q2, E_OFF, E_OFF,
                     (c <= 4) || (c == 6) || (c == 7) || (c >= 9));
         checks++;
         if (obsWord !== e) begin
            errors++;
            $display("[TB] FAIL reset_mid_ramp c=%0d got=%h want=%h", c, obsWord, e);
         end
         if (c == 5) applyStimulus(4'b0000, 1'b0, 1'b0);
         if (c == 7) begin
            applyStimulus(4'b0100, 1'b0, 1'b0);
            rst = 1'b1;
         end
         if (c == 8) rst = 1'b0;
      end
   endtask

   // Test sequence
   initial begin
      errors = 0;
      checks = 0;
      rst    = 1'b1;
      applyStimulus(4'b0000, 1'b0, 1'b0);
      test_reset();
      test_ramp_on();
      test_no_abort();
      test_sleep_wake();
      test_ssel_hold();
      test_ssel_first();
      test_back_to_back();
      test_reset_mid_ramp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
